receiver: RTL

RECEIVER -- requirements
Module: receiver

---
 rtl/receiver_if.sv | 11 +
 rtl/receiver.sv | 66 ++++++
 2 files changed

// File: rtl/receiver_if.sv
// receiver_if: serial line into the receiver and the received byte, strobe and status flags out of it.
interface receiver_if;
  logic rx_datain;
  logic [7:0] rx_data;
  logic rx_valid;
  logic rx_busy;
  logic parity_err;
  logic frame_err;
  modport master (output rx_datain, input rx_data, rx_valid, rx_busy, parity_err, frame_err);
  modport slave (input rx_datain, output rx_data, rx_valid, rx_busy, parity_err, frame_err);
endinterface

// File: rtl/receiver.sv
// receiver: 8-data/even-parity/1-stop serial receiver, CLKS_PER_BIT clocks per bit, async active-low rst.
// Define RX_INPUT_SYNC_EN to pass rx_datain through a 2-flop synchronizer (adds 2 clocks of latency).
module receiver #(
  parameter int CLKS_PER_BIT = 1
) (
  input logic clk,
  input logic rst,
  receiver_if.slave bus
);
  localparam int H = CLKS_PER_BIT / 2;
  localparam logic [7:0] N1 = 8'(CLKS_PER_BIT - 1);
  localparam logic [7:0] H1 = 8'(H > 0 ? H - 1 : 0);
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_IDLE} state_t;
  state_t state, nxt;
  logic line, tick, par;
  logic [7:0] timer, sr;
  logic [3:0] idx;
`ifdef RX_INPUT_SYNC_EN
  logic [1:0] sync;
  always_ff @(posedge clk or negedge rst)
    if (!rst) sync <= 2'b11;
    else sync <= {sync[0], bus.rx_datain};
  assign line = sync[1];
`else
  assign line = bus.rx_datain;
`endif
  assign tick = timer == N1;
  assign bus.rx_busy = state != IDLE;
  // With one clock per bit there is no mid-bit resample, so START is skipped
  always_comb begin
    nxt = state;
    case (state)
      IDLE:      if (!line) nxt = H == 0 ? DATA : START;
      START:     if (timer == H1) nxt = line ? IDLE : DATA;
      DATA:      if (tick && idx == 4'd7) nxt = PARITY;
      PARITY:    if (tick) nxt = STOP;
      STOP:      if (tick) nxt = line ? IDLE : WAIT_IDLE;
      WAIT_IDLE: if (line) nxt = IDLE;
      default:   nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= IDLE;
      timer <= 8'd0;
      idx <= 4'd0;
      sr <= 8'd0;
      par <= 1'b0;
      bus.rx_data <= 8'd0;
      bus.rx_valid <= 1'b0;
      bus.parity_err <= 1'b0;
      bus.frame_err <= 1'b0;
    end else begin
      state <= nxt;
      timer <= (nxt != state || tick || state inside {IDLE, WAIT_IDLE}) ? 8'd0 : timer + 8'd1;
      idx <= nxt == IDLE ? 4'd0 : (tick && state inside {DATA, PARITY, STOP}) ? idx + 4'd1 : idx;
      if (state == DATA && tick) sr <= {line, sr[7:1]};
      if (state == PARITY && tick) par <= line;
      bus.rx_valid <= state == STOP && tick;
      if (state == STOP && tick) begin
        bus.rx_data <= sr;
        bus.parity_err <= ^sr ^ par;
        bus.frame_err <= !line;
      end
    end
endmodule
